// File: rtl/miriscv_gpr_sb_if.sv
// Read, issue and writeback signals of the GPR scoreboard.
interface miriscv_gpr_sb_if #(
    parameter int unsigned GPR_ADDR_W = 5,
    parameter int unsigned XLEN       = 32
);
    logic [GPR_ADDR_W-1:0] rs1_addr_i;
    logic [XLEN-1:0]       rs1_data_o;
    logic                  rs1_busy_o;
    logic [GPR_ADDR_W-1:0] rs2_addr_i;
    logic [XLEN-1:0]       rs2_data_o;
    logic                  rs2_busy_o;
    logic                  issue_valid_i;
    logic [GPR_ADDR_W-1:0] issue_rd_i;
    logic                  issue_ready_o;
    logic                  wb_valid_i;
    logic [GPR_ADDR_W-1:0] wb_rd_i;
    logic [XLEN-1:0]       wb_data_i;
    logic                  wb_retire_i;
    logic                  flush_i;

    modport slave (
        input  rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
               wb_valid_i, wb_rd_i, wb_data_i, wb_retire_i, flush_i,
        output rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o, issue_ready_o
    );

    modport master (
        output rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
               wb_valid_i, wb_rd_i, wb_data_i, wb_retire_i, flush_i,
        input  rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o, issue_ready_o
    );
endinterface

// File: rtl/miriscv_gpr_sb.sv
// RV32 2-read/1-write register file with a per-register pending-write scoreboard.
// Optional macro GPR_BYPASS_EN: a writeback is forwarded to the read ports in the same cycle.
package rv_gpr_pkg;
    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
endpackage

module miriscv_gpr_sb #(
    parameter int unsigned GPR_ADDR_W = rv_gpr_pkg::GPR_ADDR_W,
    parameter int unsigned XLEN       = rv_gpr_pkg::XLEN,
    parameter int unsigned PEND_W     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    miriscv_gpr_sb_if.slave gpr
);
    localparam int unsigned       NREG     = 2 ** GPR_ADDR_W;
    localparam logic [PEND_W-1:0] MAX_PEND = '1;

    logic [XLEN-1:0]       regs    [NREG];
    logic [PEND_W-1:0]     cnt     [NREG];
    logic [PEND_W-1:0]     cnt_nxt [NREG];
    logic [GPR_ADDR_W-1:0] wb_rd;
    logic [GPR_ADDR_W-1:0] issue_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wr_en;
    logic                  dec_hit;
    logic                  inc_hit;
    logic                  issue_ready;

    assign wb_rd    = gpr.wb_rd_i;
    assign wb_data  = gpr.wb_data_i;
    assign issue_rd = gpr.issue_rd_i;

    // A retire against an idle counter is just an untracked write.
    assign wr_en   = gpr.wb_valid_i && (wb_rd != '0);
    assign dec_hit = wr_en && gpr.wb_retire_i && (cnt[wb_rd] != '0);

    // A saturated entry may still accept an issue when it retires in the same cycle.
    assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != MAX_PEND)
                       || (dec_hit && (wb_rd == issue_rd));
    assign inc_hit     = gpr.issue_valid_i && issue_ready && (issue_rd != '0) && !gpr.flush_i;
    assign gpr.issue_ready_o = issue_ready;

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (gpr.flush_i) begin
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = cnt[r]
                           + PEND_W'(inc_hit && (issue_rd == GPR_ADDR_W'(r)))
                           - PEND_W'(dec_hit && (wb_rd == GPR_ADDR_W'(r)));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[wb_rd] <= wb_data;
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_data(input logic [GPR_ADDR_W-1:0] a);
        logic [XLEN-1:0] d;
        d = regs[a];
`ifdef GPR_BYPASS_EN
        if (wr_en && (wb_rd == a)) begin
            d = wb_data;
        end
`endif
        if (a == '0) begin
            d = '0;
        end
        return d;
    endfunction

    function automatic logic rd_busy(input logic [GPR_ADDR_W-1:0] a);
        logic b;
`ifdef GPR_BYPASS_EN
        b = (cnt[a] - PEND_W'(dec_hit && (wb_rd == a))) != '0;
`else
        b = cnt[a] != '0;
`endif
        return b && (a != '0);
    endfunction

    assign gpr.rs1_data_o = rd_data(gpr.rs1_addr_i);
    assign gpr.rs2_data_o = rd_data(gpr.rs2_addr_i);
    assign gpr.rs1_busy_o = rd_busy(gpr.rs1_addr_i);
    assign gpr.rs2_busy_o = rd_busy(gpr.rs2_addr_i);

endmodule

// File: tb/tb_miriscv_gpr_sb.sv
// Scoreboard bench for miriscv_gpr_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_miriscv_gpr_sb;
    localparam int K_D1  = 0;
    localparam int K_B1  = 1;
    localparam int K_D2  = 2;
    localparam int K_B2  = 3;
    localparam int K_RDY = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    chk_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    miriscv_gpr_sb_if #(.GPR_ADDR_W(5), .XLEN(32)) gif ();

    miriscv_gpr_sb dut (
        .clk_i (clk),
        .rst_i (rst),
        .gpr   (gif.slave)
    );

    always #5 clk = ~clk;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            case (c.kind)
                K_D1:    act = gif.rs1_data_o;
                K_B1:    act = 32'(gif.rs1_busy_o);
                K_D2:    act = gif.rs2_data_o;
                K_B2:    act = 32'(gif.rs2_busy_o);
                default: act = 32'(gif.issue_ready_o);
            endcase
            n_checks++;
            if (act === c.exp) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
    end

    task automatic idle();
        gif.rs1_addr_i    = '0;
        gif.rs2_addr_i    = '0;
        gif.issue_valid_i = 1'b0;
        gif.issue_rd_i    = '0;
        gif.wb_valid_i    = 1'b0;
        gif.wb_rd_i       = '0;
        gif.wb_data_i     = '0;
        gif.wb_retire_i   = 1'b0;
        gif.flush_i       = 1'b0;
    endtask

    task automatic expect_val(input string n, input int k, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        gif.issue_valid_i = 1'b1;
        gif.issue_rd_i    = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d, input logic ret);
        gif.wb_valid_i  = 1'b1;
        gif.wb_rd_i     = rd;
        gif.wb_data_i   = d;
        gif.wb_retire_i = ret;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Out of reset
        gif.rs1_addr_i = 5'd5;
        gif.rs2_addr_i = 5'd7;
        gif.issue_rd_i = 5'd5;
        expect_val("por_d1", K_D1, 32'h0);
        expect_val("por_b1", K_B1, 32'h0);
        expect_val("por_b2", K_B2, 32'h0);
        expect_val("por_rdy", K_RDY, 32'h1);
        tick();

        // Reset clears written data
        wb(5'd5, 32'hDEADBEEF, 1'b0);
        tick();
        gif.rs1_addr_i = 5'd5;
        expect_val("wr_x5", K_D1, 32'hDEADBEEF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gif.rs1_addr_i = 5'd5;
        gif.issue_rd_i = 5'd5;
        expect_val("rst_d1", K_D1, 32'h0);
        expect_val("rst_b1", K_B1, 32'h0);
        expect_val("rst_rdy", K_RDY, 32'h1);
        tick();

        // x0 is immutable and untracked
        wb(5'd0, 32'hFFFFFFFF, 1'b1);
        issue(5'd0);
        expect_val("x0_rdy", K_RDY, 32'h1);
        tick();
        gif.rs1_addr_i = 5'd0;
        gif.rs2_addr_i = 5'd0;
        expect_val("x0_d1", K_D1, 32'h0);
        expect_val("x0_b1", K_B1, 32'h0);
        expect_val("x0_d2", K_D2, 32'h0);
        expect_val("x0_b2", K_B2, 32'h0);
        tick();

        // RAW hazard on x7
        issue(5'd7);
        tick();
        gif.rs1_addr_i = 5'd7;
        expect_val("raw_busy", K_B1, 32'h1);
        expect_val("raw_old", K_D1, 32'h0);
        tick();
        gif.rs1_addr_i = 5'd7;
        wb(5'd7, 32'h1234, 1'b1);
`ifdef GPR_BYPASS_EN
        expect_val("raw_wb_busy", K_B1, 32'h0);
        expect_val("raw_wb_data", K_D1, 32'h1234);
`else
        expect_val("raw_wb_busy", K_B1, 32'h1);
        expect_val("raw_wb_data", K_D1, 32'h0);
`endif
        tick();
        gif.rs1_addr_i = 5'd7;
        expect_val("raw_after_busy", K_B1, 32'h0);
        expect_val("raw_after_data", K_D1, 32'h1234);
        tick();

        // Saturation on x3
        for (int i = 0; i < 3; i++) begin
            issue(5'd3);
            expect_val("sat_rdy_fill", K_RDY, 32'h1);
            tick();
        end
        gif.issue_rd_i = 5'd3;
        gif.rs2_addr_i = 5'd3;
        expect_val("sat_rdy_full", K_RDY, 32'h0);
        expect_val("sat_busy", K_B2, 32'h1);
        tick();
        issue(5'd3);
        wb(5'd3, 32'h33, 1'b1);
        expect_val("sat_rdy_retire", K_RDY, 32'h1);
        tick();
        gif.issue_rd_i = 5'd3;
        expect_val("sat_still_full", K_RDY, 32'h0);
        tick();
        wb(5'd3, 32'h34, 1'b1);
        tick();
        wb(5'd3, 32'h35, 1'b1);
        tick();
        gif.rs2_addr_i = 5'd3;
        gif.issue_rd_i = 5'd3;
        expect_val("sat_drain_busy", K_B2, 32'h1);
        expect_val("sat_drain_rdy", K_RDY, 32'h1);
        expect_val("sat_drain_data", K_D2, 32'h35);
        tick();
        wb(5'd3, 32'h36, 1'b1);
        tick();
        gif.rs2_addr_i = 5'd3;
        expect_val("sat_empty_busy", K_B2, 32'h0);
        tick();

        // Simultaneous issue and retire on x9
        issue(5'd9);
        tick();
        issue(5'd9);
        wb(5'd9, 32'h99, 1'b1);
        tick();
        gif.rs1_addr_i = 5'd9;
        expect_val("sim_busy", K_B1, 32'h1);
        expect_val("sim_data", K_D1, 32'h99);
        tick();
        wb(5'd9, 32'h9A, 1'b1);
        tick();
        gif.rs1_addr_i = 5'd9;
        expect_val("sim_drained", K_B1, 32'h0);
        tick();

        // Flush
        issue(5'd4);
        tick();
        issue(5'd4);
        tick();
        issue(5'd6);
        tick();
        gif.rs1_addr_i = 5'd4;
        gif.rs2_addr_i = 5'd6;
        expect_val("fl_pre_b4", K_B1, 32'h1);
        expect_val("fl_pre_b6", K_B2, 32'h1);
        tick();
        gif.flush_i = 1'b1;
        issue(5'd8);
        wb(5'd4, 32'h55, 1'b1);
        tick();
        gif.rs1_addr_i = 5'd4;
        gif.rs2_addr_i = 5'd6;
        expect_val("fl_b4", K_B1, 32'h0);
        expect_val("fl_d4", K_D1, 32'h55);
        expect_val("fl_b6", K_B2, 32'h0);
        tick();
        gif.rs1_addr_i = 5'd8;
        expect_val("fl_b8", K_B1, 32'h0);
        tick();
        tick();

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
